network_rbfu_in_pipe: RTL

//  Elastic, parametrised bank-to-RBFU input network. Each accepted beat carries N_LANES

---
 rtl/network_rbfu_in_pipe_pkg.sv | 15 +
 rtl/network_rbfu_in_pipe_lane_xbar.sv | 59 +++++
 rtl/network_rbfu_in_pipe.sv | 94 +++++++++
 3 files changed

// File: rtl/network_rbfu_in_pipe_pkg.sv
// Shared definitions for the bank-to-RBFU input network: routing modes and default sizing.
package network_rbfu_in_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_SCATTER = 2'b00,
    MODE_GATHER  = 2'b01,
    MODE_BYPASS  = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  localparam int DEF_N_LANES     = 4;
  localparam int DEF_DATA_WIDTH  = 12;
  localparam int DEF_PIPE_STAGES = 2;

endpackage

// File: rtl/network_rbfu_in_pipe_lane_xbar.sv
// Combinational lane crossbar: routes N words by per-lane selects under SCATTER/GATHER/BYPASS,
// flagging SCATTER beats whose selects collide on a destination lane.
module network_rbfu_in_pipe_lane_xbar
  import network_rbfu_in_pipe_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 12,
  parameter int SELW = 2
) (
  input  logic [1:0]        mode,
  input  logic [N*SELW-1:0] sel_bus,
  input  logic [N*W-1:0]    q_bus,
  output logic [N*W-1:0]    out_bus,
  output logic              dup
);

  logic [SELW-1:0] sel_a [N];
  logic [W-1:0]    q_a   [N];
  logic [W-1:0]    out_a [N];
  logic [N-1:0]    claimed;
  mode_e           mode_s;

  assign mode_s = mode_e'(mode);

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_lane
      assign sel_a[g]            = sel_bus[g*SELW +: SELW];
      assign q_a[g]              = q_bus[g*W +: W];
      assign out_bus[g*W +: W]   = out_a[g];
    end
  endgenerate

  // Scanning sources upward and skipping already-claimed lanes makes the lowest source win.
  always_comb begin
    claimed = '0;
    dup     = 1'b0;
    for (int i = 0; i < N; i++) out_a[i] = '0;
    case (mode_s)
      MODE_SCATTER: begin
        for (int i = 0; i < N; i++) begin
          if (claimed[sel_a[i]]) begin
            dup = 1'b1;
          end else begin
            claimed[sel_a[i]] = 1'b1;
            out_a[sel_a[i]]   = q_a[i];
          end
        end
      end
      MODE_GATHER: begin
        for (int i = 0; i < N; i++) out_a[i] = q_a[sel_a[i]];
      end
      default: begin
        for (int i = 0; i < N; i++) out_a[i] = q_a[i];
      end
    endcase
  end

endmodule

// File: rtl/network_rbfu_in_pipe.sv
// Elastic bank-to-RBFU input network: lane permutation registered in stage 1, then pure delay,
// under a global-stall valid/ready pipeline with a sticky SCATTER collision flag.
module network_rbfu_in_pipe
  import network_rbfu_in_pipe_pkg::*;
#(
  parameter int N_LANES     = DEF_N_LANES,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SELW        = $clog2(N_LANES),
  parameter int PIPE_STAGES = DEF_PIPE_STAGES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    mode,
  input  logic [N_LANES*SELW-1:0]       sel_bus,
  input  logic [N_LANES*DATA_WIDTH-1:0] q_bus,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_LANES*DATA_WIDTH-1:0] rbfu_bus,
  output logic                          perm_err,
  input  logic                          err_clr
);

  localparam int BUSW = N_LANES * DATA_WIDTH;

  logic [BUSW-1:0]        xbar_s;
  logic                   dup_s;
  logic                   advance_s;
  logic                   accept_s;
  logic [BUSW-1:0]        data_q [PIPE_STAGES];
  logic [BUSW-1:0]        data_d [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] valid_q;
  logic [PIPE_STAGES-1:0] valid_d;
  logic                   perm_err_q;
  logic                   perm_err_d;

  network_rbfu_in_pipe_lane_xbar #(
    .N    (N_LANES),
    .W    (DATA_WIDTH),
    .SELW (SELW)
  ) u_xbar (
    .mode    (mode),
    .sel_bus (sel_bus),
    .q_bus   (q_bus),
    .out_bus (xbar_s),
    .dup     (dup_s)
  );

  // in_ready is forced low while reset is sampled so nothing is accepted into a flushing pipe.
  assign advance_s = out_ready || !valid_q[PIPE_STAGES-1];
  assign in_ready  = advance_s && rst;
  assign accept_s  = in_valid && in_ready;

  // Data registers only load real beats; bubbles leave stale words untouched.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (advance_s) begin
      valid_d[0] = accept_s;
      data_d[0]  = accept_s ? xbar_s : data_q[0];
      for (int k = 1; k < PIPE_STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = valid_q[k-1] ? data_q[k-1] : data_q[k];
      end
    end else begin
      valid_d = valid_q;
    end
    if (accept_s && dup_s) begin
      perm_err_d = 1'b1;
    end else if (err_clr) begin
      perm_err_d = 1'b0;
    end else begin
      perm_err_d = perm_err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= '0;
      perm_err_q <= 1'b0;
      for (int k = 0; k < PIPE_STAGES; k++) data_q[k] <= '0;
    end else begin
      valid_q    <= valid_d;
      perm_err_q <= perm_err_d;
      for (int k = 0; k < PIPE_STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  assign out_valid = valid_q[PIPE_STAGES-1];
  assign rbfu_bus  = data_q[PIPE_STAGES-1];
  assign perm_err  = perm_err_q;

endmodule
